// File: rtl/apb_lsu_master.sv
// apb_lsu_master: RV32I load/store unit issuing one APB transfer per core request.
// Latency: done 3 cycles after req for a zero-wait transfer (+1 per PREADY wait state), 1 cycle for illegal requests.
// Backpressure: req is sampled only in IDLE; PREADY low stretches ACCESS (bounded by TIMEOUT_CYCLES when APB_TIMEOUT_EN is defined).
module apb_lsu_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wData,
    output logic [31:0] rData,
    output logic        done,
    output logic        err,
    output logic [31:0] PADDR,
    output logic        PSEL,
    output logic        PENABLE,
    output logic        PWRITE,
    output logic [31:0] PWDATA,
    output logic [3:0]  PSTRB,
    input  logic [31:0] PRDATA,
    input  logic        PREADY,
    input  logic        PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t      state;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        illegal;
    logic [31:0] st_dat;
    logic [3:0]  st_strb;

`ifdef APB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tcnt;
`endif

    // Extract the addressed byte/halfword lane and extend it according to funct3.
    function automatic logic [31:0] load_fmt(input logic [2:0]  f3,
                                             input logic [1:0]  off,
                                             input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  load_fmt = {{24{b[7]}}, b};
            3'b001:  load_fmt = {{16{h[15]}}, h};
            3'b100:  load_fmt = {24'd0, b};
            3'b101:  load_fmt = {16'd0, h};
            default: load_fmt = d;
        endcase
    endfunction

    // Legality check and store lane placement, evaluated on the live request fields.
    always_comb begin
        illegal = 1'b0;
        st_dat  = 32'd0;
        st_strb = 4'd0;
        case (funct3)
            3'b000:         illegal = 1'b0;
            3'b001:         illegal = addr[0];
            3'b010:         illegal = |addr[1:0];
            3'b100, 3'b101: illegal = we | (funct3[0] & addr[0]);
            default:        illegal = 1'b1;
        endcase
        if (we) begin
            case (funct3[1:0])
                2'b00: begin
                    st_dat  = {4{wData[7:0]}};
                    st_strb = 4'b0001 << addr[1:0];
                end
                2'b01: begin
                    st_dat  = {2{wData[15:0]}};
                    st_strb = 4'b0011 << {addr[1], 1'b0};
                end
                2'b10: begin
                    st_dat  = wData;
                    st_strb = 4'b1111;
                end
                default: begin
                    st_dat  = 32'd0;
                    st_strb = 4'd0;
                end
            endcase
        end
    end

    // Transfer FSM; every output is a register so APB pins never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            rData   <= 32'd0;
            done    <= 1'b0;
            err     <= 1'b0;
            PADDR   <= 32'd0;
            PSEL    <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PWDATA  <= 32'd0;
            PSTRB   <= 4'd0;
`ifdef APB_TIMEOUT_EN
            tcnt    <= '0;
`endif
        end else begin
            // Completion signals are single-cycle pulses unless set below.
            done  <= 1'b0;
            err   <= 1'b0;
            rData <= 32'd0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (illegal) begin
                            // Rejected without touching the bus.
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            we_q   <= we;
                            f3_q   <= funct3;
                            off_q  <= addr[1:0];
                            PADDR  <= {addr[31:2], 2'b00};
                            PWRITE <= we;
                            PWDATA <= st_dat;
                            PSTRB  <= st_strb;
                            PSEL   <= 1'b1;
                            state  <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    tcnt    <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        // PREADY wins over a timeout decided in the same cycle.
                        state   <= IDLE;
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
                        PADDR   <= 32'd0;
                        PWRITE  <= 1'b0;
                        PWDATA  <= 32'd0;
                        PSTRB   <= 4'd0;
                        done    <= 1'b1;
                        err     <= PSLVERR;
                        rData   <= (PSLVERR || we_q) ? 32'd0 : load_fmt(f3_q, off_q, PRDATA);
                    end
`ifdef APB_TIMEOUT_EN
                    else begin
                        tcnt <= tcnt + TW'(1);
                        if (tcnt == T_LAST) begin
                            // Slave never answered: abandon the transfer.
                            state   <= IDLE;
                            PSEL    <= 1'b0;
                            PENABLE <= 1'b0;
                            PADDR   <= 32'd0;
                            PWRITE  <= 1'b0;
                            PWDATA  <= 32'd0;
                            PSTRB   <= 4'd0;
                            done    <= 1'b1;
                            err     <= 1'b1;
                        end
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/apb_lsu_master.md
# apb_lsu_master

Load/store initiator of the multi-cycle RV32I core: accepts one memory request per transaction from the execute/memory stage and issues it as an APB transfer toward RAM and peripherals. It performs byte/halfword lane placement on stores with PSTRB generation, and lane extraction with sign/zero extension on loads. It also rejects misaligned or unsupported accesses, and reports completion and errors back to the core's control FSM.

## Interface
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles allowed before abort (only with APB_TIMEOUT_EN); ≥2
- clk  in  1  core clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- req  in  1  core request; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- funct3  in  3  RV32I width code: 000 b, 001 h, 010 w, 100 bu, 101 hu
- addr  in  32  byte address
- wData  in  32  store data (low-aligned)
- rData  out  32  formatted load data; valid while done=1
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned, bad funct3, PSLVERR or timeout
- PADDR  out  32  word address {addr[31:2],2'b00}
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PWDATA  out  32  lane-replicated store data
- PSTRB  out  4  byte strobes
- PRDATA  in  32  read data
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error

## Operation
- FSM: IDLE, SETUP, ACCESS. Request fields captured into registers on acceptance; core need not hold them.
- IDLE: req=1 and legal -> SETUP. req=1 and illegal -> stay IDLE, next cycle done=1, err=1, rData=0, no APB activity.
- Illegal: funct3 ∈ {011,110,111}; store with funct3 ∈ {100,101}; halfword with addr[0]=1; word with addr[1:0]≠0.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB driven from captured fields -> ACCESS unconditionally.
- ACCESS: PSEL=1, PENABLE=1. PREADY=1 -> IDLE, next cycle done=1. PREADY=0 -> stay. All APB outputs stable throughout.
- Store lanes: sb PWDATA={4{wData[7:0]}}, PSTRB=4'b0001<<addr[1:0]; sh PWDATA={2{wData[15:0]}}, PSTRB=4'b0011<<{addr[1],1'b0}; sw PWDATA=wData, PSTRB=4'b1111.
- Loads: PWRITE=0, PSTRB=0, PWDATA=0. PRDATA captured on the PREADY cycle. Byte = PRDATA[8*addr[1:0]+:8], half = PRDATA[16*addr[1]+:16]; sign-extended for 000/001, zero-extended for 100/101, word passed through.
- PSLVERR sampled with PREADY=1: done=1, err=1, rData=0. Store is considered not performed.
- req ignored in SETUP/ACCESS. In the done cycle the FSM is in IDLE and may accept a new req.
- PSEL/PENABLE deassert in the cycle following the PREADY cycle (IDLE).

## Timing
- Reset: state IDLE. All outputs 0: rData, done, err, PADDR, PSEL, PENABLE, PWRITE, PWDATA, PSTRB. Timeout counter 0.
- Zero-wait transfer: req at cycle 0, SETUP cycle 1, ACCESS cycle 2 (PREADY=1), done cycle 3. Each PREADY wait state adds 1 cycle.
- Illegal request: req cycle 0, done+err cycle 1.
- done and err are single-cycle pulses; err=0 whenever done=0.
- Reset asserted mid-transfer: next edge IDLE, PSEL=PENABLE=0, no done pulse, captured request discarded.

## Configuration
- APB_TIMEOUT_EN defined: counter cleared on entering ACCESS and incremented each ACCESS cycle with PREADY=0. When it reaches TIMEOUT_CYCLES, the transfer aborts: IDLE next cycle, PSEL/PENABLE low, done=1, err=1, rData=0. PREADY arriving on the abort-decision cycle takes priority (normal completion).
- Undefined: no counter; ACCESS waits indefinitely; err sources are illegal request and PSLVERR only.

## Test plan
- lb at addr 0x0000_0013, PRDATA=0x80FF_1234, PREADY=1 immediately -> PADDR=0x10, PSTRB=0, done at cycle 3, rData=0xFFFF_FF80, err=0.
- lhu at 0x0000_0006, PRDATA=0x8001_7FFF, 2 wait states -> done at cycle 5, rData=0x0000_8001.
- sb at 0x0000_0021, wData=0xDEAD_BEAB -> PADDR=0x20, PWRITE=1, PWDATA=0xABAB_ABAB, PSTRB=4'b0010; sh at 0x22 -> PSTRB=4'b1100, PWDATA={2{16'hBEAB}}.
- lw at 0x0000_0002 -> no PSEL assertion, done=1/err=1 at cycle 1; PSLVERR=1 with PREADY on a sw -> done=1, err=1, rData=0.
- APB_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY held 0 -> abort with done/err after 4 ACCESS cycles, PSEL low; without macro, still in ACCESS after 100 cycles.
- reset asserted during ACCESS -> PSEL=PENABLE=0 next edge, no done; a new lw accepted right after reset release completes normally.
